// File: rtl/ifetch48_pkg.sv
// Shared constants and types for the 48-bit instruction fetch unit:
// instruction/memory widths, bubble encoding, word placement and phase states.
package ifetch48_pkg;

  localparam int INSTR_W = 48;
  localparam int IM_W    = 16;

  // Bubble is LLB R0,#0, which encodes as all zeros.
  localparam logic [INSTR_W-1:0] NOP_ENC = 48'h0;

  // Bit positions of the three IM words inside an instruction, in fetch order.
  localparam int HI_LSB  = 32;
  localparam int MID_LSB = 16;
  localparam int LO_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE0 = 2'd0,
    W1    = 2'd1,
    W2    = 2'd2
  } phase_e;

  function automatic logic [INSTR_W-1:0] assemble(input logic [IM_W-1:0] hi,
                                                  input logic [IM_W-1:0] mid,
                                                  input logic [IM_W-1:0] lo);
    logic [INSTR_W-1:0] w;
    w                   = '0;
    w[HI_LSB  +: IM_W]  = hi;
    w[MID_LSB +: IM_W]  = mid;
    w[LO_LSB  +: IM_W]  = lo;
    return w;
  endfunction

endpackage

// File: rtl/ifetch48_ifq_fifo.sv
// Prefetch queue: DEPTH entries of W bits, wrap-around pointers plus an
// occupancy count. Flush beats push and pop.
module ifq_fifo #(
  parameter int  DEPTH = 2,
  parameter int  W     = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [W-1:0]     wdata_i,
  output logic [W-1:0]     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // NOTE: storage has no reset; entries are only observable once count_q says
  // they were written, so resetting them would buy nothing.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/ifetch48.sv
// Instruction fetch: reads 16-bit IM words, assembles 48-bit instructions,
// queues them and presents the head to decode with stall/redirect handling.
module ifetch48
  import ifetch48_pkg::*;
#(
  parameter int                 PC_W      = 16,
  parameter int                 QDEPTH    = 2,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_ENC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_IM_ID,
  input  logic               flow_change_ID_EX,
  input  logic [PC_W-1:0]    dst_ID_EX,
  input  logic [IM_W-1:0]    im_rd_data,
  output logic               im_re,
  output logic [PC_W-1:0]    im_addr,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_vld,
  output logic [PC_W-1:0]    nxt_pc
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam int ENT_W = INSTR_W + PC_W;

  phase_e            phase_q;
  logic [PC_W-1:0]   pc_q, pc_d, rd_addr_q, push_pc;
  logic [1:0]        iss_ph_q, iss_ph_d;
  logic              inflight_q, capture, asm_busy;
  logic [IM_W-1:0]   asm_hi_q, asm_mid_q;
  logic [CNT_W:0]    occ;

  logic              q_push, q_pop, q_full, q_empty;
  logic [CNT_W-1:0]  q_count;
  logic [ENT_W-1:0]  q_head, q_wdata;

  // An unfinished instruction reserves one queue slot; its remaining words may
  // always issue, but a new instruction only starts when a slot is free.
  assign asm_busy = (phase_q != IDLE0) || inflight_q;
  assign occ      = {1'b0, q_count} + {{CNT_W{1'b0}}, asm_busy};
  assign im_re    = rst_n && !flow_change_ID_EX && !q_full &&
                    ((iss_ph_q != 2'd0) || (occ < (CNT_W+1)'(QDEPTH)));
  assign im_addr  = pc_q;

  assign capture  = inflight_q && !flow_change_ID_EX;
  assign q_push   = capture && (phase_q == W2);
  assign push_pc  = rd_addr_q + PC_W'(1);
  assign q_wdata  = {assemble(asm_hi_q, asm_mid_q, im_rd_data), push_pc};
  assign q_pop    = !q_empty && !stall_IM_ID && !flow_change_ID_EX;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latch.
    pc_d     = pc_q;
    iss_ph_d = iss_ph_q;
    if (flow_change_ID_EX) begin
      pc_d     = dst_ID_EX;
      iss_ph_d = 2'd0;
    end else if (im_re) begin
      pc_d     = pc_q + PC_W'(1);
      iss_ph_d = (iss_ph_q == 2'd2) ? 2'd0 : iss_ph_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      iss_ph_q   <= '0;
      rd_addr_q  <= '0;
      inflight_q <= 1'b0;
      asm_hi_q   <= '0;
      asm_mid_q  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      pc_q       <= pc_d;
      iss_ph_q   <= iss_ph_d;
      inflight_q <= im_re;
      if (im_re) rd_addr_q <= pc_q;
      if (capture && phase_q == IDLE0) asm_hi_q  <= im_rd_data;
      if (capture && phase_q == W1)    asm_mid_q <= im_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= IDLE0;
    end else if (flow_change_ID_EX) begin
      phase_q <= IDLE0;
    end else if (capture) begin
      case (phase_q)
        IDLE0:   phase_q <= W1;
        W1:      phase_q <= W2;
        default: phase_q <= IDLE0;
      endcase
    end
  end

  ifq_fifo #(
    .DEPTH (QDEPTH),
    .W     (ENT_W)
  ) u_ifq (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .flush_i (flow_change_ID_EX),
    .wdata_i (q_wdata),
    .head_o  (q_head),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign instr_vld = !q_empty;
  assign instr     = q_empty ? NOP_INSTR : q_head[ENT_W-1 -: INSTR_W];
  assign nxt_pc    = q_empty ? '0 : q_head[PC_W-1:0];

endmodule

// File: tb/tb_ifetch48.sv
// Bench for ifetch48: behavioural IM, expected instructions queued per scenario
// and compared when decode sees them.
module tb_ifetch48;

  logic        clk = 1'b0;
  logic        rst_n, stall, flow;
  logic [15:0] dst;
  logic [15:0] im_rd_data;
  logic        im_re, instr_vld;
  logic [15:0] im_addr, nxt_pc;
  logic [47:0] instr;

  typedef struct packed {
    logic [47:0] ins;
    logic [15:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [15:0] mem [0:65535];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  ifetch48 dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_IM_ID       (stall),
    .flow_change_ID_EX (flow),
    .dst_ID_EX         (dst),
    .im_rd_data        (im_rd_data),
    .im_re             (im_re),
    .im_addr           (im_addr),
    .instr             (instr),
    .instr_vld         (instr_vld),
    .nxt_pc            (nxt_pc)
  );

  always @(posedge clk) if (im_re) im_rd_data <= mem[im_addr];

  // Queue overflow must never happen: the issue rule has to prevent it.
  always @(posedge clk) begin
    if (rst_n && dut.q_push && dut.q_full && !flow) begin
      n_fail++;
      $display("FAIL q_overflow: push while full at %0t", $time);
    end
  end

  function automatic exp_t exp_at(input logic [15:0] a);
    logic [15:0] a1, a2;
    a1 = a + 16'd1;
    a2 = a + 16'd2;
    return {mem[a], mem[a1], mem[a2], a + 16'd3};
  endfunction

  task automatic do_reset;
    rst_n = 1'b0; stall = 1'b0; flow = 1'b0; dst = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic next_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_vld(input int max, output bit ok, output int waited);
    waited = 0;
    while (!instr_vld && waited < max) begin
      @(negedge clk);
      waited++;
    end
    ok = instr_vld;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    n_tests++; if (im_re !== 1'b0)    begin n_fail++; $display("FAIL rst_im_re: got %b want 0", im_re); end
    n_tests++; if (im_addr !== 16'h0) begin n_fail++; $display("FAIL rst_im_addr: got %h want 0", im_addr); end
    n_tests++; if (instr !== 48'h0)   begin n_fail++; $display("FAIL rst_instr: got %h want 0", instr); end
    n_tests++; if (instr_vld !== 1'b0) begin n_fail++; $display("FAIL rst_vld: got %b want 0", instr_vld); end
    n_tests++; if (nxt_pc !== 16'h0)  begin n_fail++; $display("FAIL rst_nxt_pc: got %h want 0", nxt_pc); end
  endtask

  task automatic test_first_fetch;
    do_reset();
    exp_q.push_back({48'h0A1B2C3D4E5F, 16'd3});
    exp_q.push_back({48'h123456789ABC, 16'd6});
    release_reset();
    n_tests++; if ({im_re, im_addr} !== {1'b1, 16'h0}) begin n_fail++; $display("FAIL ff_issue0: got re=%b addr=%h want re=1 addr=0000", im_re, im_addr); end
    for (int k = 1; k <= 3; k++) begin
      next_cycles(1);
      n_tests++; if (instr_vld !== 1'b0) begin n_fail++; $display("FAIL ff_early_vld cycle %0d: got %b want 0", k, instr_vld); end
    end
    next_cycles(1);
    e = exp_q.pop_front();
    n_tests++; if ({instr_vld, instr, nxt_pc} !== {1'b1, e.ins, e.pc}) begin n_fail++; $display("FAIL ff_first: got vld=%b %h pc=%h want vld=1 %h pc=%h", instr_vld, instr, nxt_pc, e.ins, e.pc); end
    for (int k = 5; k <= 6; k++) begin
      next_cycles(1);
      n_tests++; if (instr_vld !== 1'b0) begin n_fail++; $display("FAIL ff_gap_vld cycle %0d: got %b want 0", k, instr_vld); end
    end
    next_cycles(1);
    e = exp_q.pop_front();
    n_tests++; if ({instr_vld, instr, nxt_pc} !== {1'b1, e.ins, e.pc}) begin n_fail++; $display("FAIL ff_second: got vld=%b %h pc=%h want vld=1 %h pc=%h", instr_vld, instr, nxt_pc, e.ins, e.pc); end
  endtask

  task automatic test_stall;
    bit ok; int w; int reads;
    do_reset();
    exp_q.push_back(exp_at(16'd0));
    exp_q.push_back(exp_at(16'd3));
    release_reset();
    wait_vld(10, ok, w);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL st_timeout: got vld=0 want vld=1 within 10 cycles"); end
    stall = 1'b1;
    reads = int'(im_re);
    for (int i = 0; i < 10; i++) begin
      next_cycles(1);
      n_tests++; if ({instr_vld, instr} !== {1'b1, exp_q[0].ins}) begin n_fail++; $display("FAIL st_hold %0d: got vld=%b %h want vld=1 %h", i, instr_vld, instr, exp_q[0].ins); end
      if (i < 9) reads += int'(im_re);
    end
    n_tests++; if (reads !== 2) begin n_fail++; $display("FAIL st_reads: got %0d want 2", reads); end
    n_tests++; if (im_re !== 1'b0) begin n_fail++; $display("FAIL st_re_blocked: got %b want 0", im_re); end
    stall = 1'b0;
    e = exp_q.pop_front();
    n_tests++; if ({instr_vld, instr, nxt_pc} !== {1'b1, e.ins, e.pc}) begin n_fail++; $display("FAIL st_rel0: got vld=%b %h pc=%h want vld=1 %h pc=%h", instr_vld, instr, nxt_pc, e.ins, e.pc); end
    next_cycles(1);
    e = exp_q.pop_front();
    n_tests++; if ({instr_vld, instr, nxt_pc} !== {1'b1, e.ins, e.pc}) begin n_fail++; $display("FAIL st_rel1: got vld=%b %h pc=%h want vld=1 %h pc=%h", instr_vld, instr, nxt_pc, e.ins, e.pc); end
  endtask

  task automatic test_redirect;
    bit ok; int w;
    do_reset();
    release_reset();
    next_cycles(2);
    flow = 1'b1; dst = 16'h0040;
    exp_q.push_back(exp_at(16'h0040));
    #1;
    n_tests++; if (im_re !== 1'b0) begin n_fail++; $display("FAIL rd_re_in_redirect: got %b want 0", im_re); end
    next_cycles(1);
    flow = 1'b0;
    #1;
    n_tests++; if ({instr_vld, instr} !== {1'b0, 48'h0}) begin n_fail++; $display("FAIL rd_bubble: got vld=%b %h want vld=0 0", instr_vld, instr); end
    n_tests++; if ({im_re, im_addr} !== {1'b1, 16'h0040}) begin n_fail++; $display("FAIL rd_target: got re=%b addr=%h want re=1 addr=0040", im_re, im_addr); end
    wait_vld(8, ok, w);
    e = exp_q.pop_front();
    n_tests++; if ({instr_vld, instr, nxt_pc} !== {1'b1, e.ins, e.pc}) begin n_fail++; $display("FAIL rd_first: got vld=%b %h pc=%h want vld=1 %h pc=%h", instr_vld, instr, nxt_pc, e.ins, e.pc); end
  endtask

  task automatic test_redirect_push_pop;
    do_reset();
    release_reset();
    next_cycles(4);
    stall = 1'b1;
    n_tests++; if (instr_vld !== 1'b1) begin n_fail++; $display("FAIL rpp_head: got vld=%b want 1", instr_vld); end
    next_cycles(2);
    stall = 1'b0; flow = 1'b1; dst = 16'h0080;
    exp_q.push_back(exp_at(16'h0080));
    for (int k = 7; k <= 10; k++) begin
      next_cycles(1);
      flow = 1'b0;
      n_tests++; if ({instr_vld, instr} !== {1'b0, 48'h0}) begin n_fail++; $display("FAIL rpp_empty cycle %0d: got vld=%b %h want vld=0 0", k, instr_vld, instr); end
    end
    next_cycles(1);
    e = exp_q.pop_front();
    n_tests++; if ({instr_vld, instr, nxt_pc} !== {1'b1, e.ins, e.pc}) begin n_fail++; $display("FAIL rpp_first: got vld=%b %h pc=%h want vld=1 %h pc=%h", instr_vld, instr, nxt_pc, e.ins, e.pc); end
  endtask

  task automatic test_pc_wrap;
    bit ok; int w;
    logic [15:0] want_addr [3];
    want_addr[0] = 16'hFFFE; want_addr[1] = 16'hFFFF; want_addr[2] = 16'h0000;
    do_reset();
    release_reset();
    next_cycles(1);
    flow = 1'b1; dst = 16'hFFFE;
    exp_q.push_back(exp_at(16'hFFFE));
    for (int i = 0; i < 3; i++) begin
      next_cycles(1);
      flow = 1'b0;
      #1;
      n_tests++; if ({im_re, im_addr} !== {1'b1, want_addr[i]}) begin n_fail++; $display("FAIL wrap_addr %0d: got re=%b addr=%h want re=1 addr=%h", i, im_re, im_addr, want_addr[i]); end
    end
    wait_vld(8, ok, w);
    e = exp_q.pop_front();
    n_tests++; if ({instr_vld, instr, nxt_pc} !== {1'b1, e.ins, 16'h0001}) begin n_fail++; $display("FAIL wrap_instr: got vld=%b %h pc=%h want vld=1 %h pc=0001", instr_vld, instr, nxt_pc, e.ins); end
  endtask

  task automatic test_reset_mid;
    bit ok; int w;
    do_reset();
    release_reset();
    next_cycles(4);
    stall = 1'b1;
    next_cycles(1);
    n_tests++; if (instr_vld !== 1'b1) begin n_fail++; $display("FAIL rm_pre_vld: got %b want 1", instr_vld); end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if ({im_re, im_addr, instr, instr_vld, nxt_pc} !== {1'b0, 16'h0, 48'h0, 1'b0, 16'h0}) begin n_fail++; $display("FAIL rm_async: got re=%b addr=%h %h vld=%b pc=%h want all zero", im_re, im_addr, instr, instr_vld, nxt_pc); end
    stall = 1'b0;
    exp_q.push_back(exp_at(16'd0));
    release_reset();
    n_tests++; if ({im_re, im_addr} !== {1'b1, 16'h0}) begin n_fail++; $display("FAIL rm_restart: got re=%b addr=%h want re=1 addr=0000", im_re, im_addr); end
    wait_vld(10, ok, w);
    e = exp_q.pop_front();
    n_tests++; if ({instr_vld, instr, nxt_pc, w} !== {1'b1, e.ins, e.pc, 32'd4}) begin n_fail++; $display("FAIL rm_first: got vld=%b %h pc=%h after %0d cycles want vld=1 %h pc=%h after 4", instr_vld, instr, nxt_pc, w, e.ins, e.pc); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'((i * 935) ^ 23644);
    mem[0] = 16'h0A1B; mem[1] = 16'h2C3D; mem[2] = 16'h4E5F;
    mem[3] = 16'h1234; mem[4] = 16'h5678; mem[5] = 16'h9ABC;
    rst_n = 1'b0; stall = 1'b0; flow = 1'b0; dst = '0;
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect();
    test_redirect_push_pop();
    test_pc_wrap();
    test_reset_mid();
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d left want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch48.md
Name: ifetch48

Overview:
- Instruction fetch unit; the producer end of the 48-bit instruction interface that the decode stage consumes.
- Reads 16-bit words from a synchronous instruction memory and assembles them into 48-bit instructions.
- Buffers assembled instructions in a small prefetch queue and presents them to decode, honouring decode stalls and flow-change redirects.
- Presents a bubble (LLB R0,#0 = all zeros) whenever no valid instruction is available.

Parameters:
- PC_W, 16: width of word-address PC and memory address.
- QDEPTH, 2: prefetch queue depth in instructions, power of 2, minimum 2.
- NOP_INSTR, 48'h0: bubble instruction, LLB R0,#0.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall_IM_ID  in  1  decode stall; the presented instruction is not consumed.
- flow_change_ID_EX  in  1  taken branch, jump or JR; redirect fetch.
- dst_ID_EX  in  PC_W  redirect target word address, valid with flow_change_ID_EX.
- im_rd_data  in  16  IM read data, valid the cycle after im_re.
- im_re  out  1  IM read enable.
- im_addr  out  PC_W  IM word address.
- instr  out  48  instruction to decode.
- instr_vld  out  1  instr is a real fetched instruction, not a bubble.
- nxt_pc  out  PC_W  address of the presented instruction + 3.

Behaviour:
- Reset (async, rst_n low):
  - fetch PC = 0, phase = 0, queue empty, in-flight flag clear.
  - im_re = 0, im_addr = 0.
  - instr = NOP_INSTR, instr_vld = 0, nxt_pc = 0.
- Instruction word order: word at A supplies instr[47:32], A+1 supplies [31:16], A+2 supplies [15:0].
- Issue:
  - im_re = 1 when (queue count + in-flight assembly) < QDEPTH and no redirect this cycle.
  - im_addr = fetch PC; fetch PC increments by 1 per issued read.
  - PC wraps modulo 2^PC_W.
- Capture:
  - The cycle after an issued read, im_rd_data is written into the assembly register slot selected by phase (0, 1, 2).
  - phase advances 0→1→2→0.
  - On the phase-2 capture, the assembled 48 bits plus start address + 3 are pushed into the queue the same clock.
- Phase state machine:
  - Three states, IDLE0 / W1 / W2.
  - A state transition occurs only on a captured word.
  - A redirect forces IDLE0.
- Presentation:
  - Queue head drives instr and nxt_pc combinationally; instr_vld = queue non-empty.
  - When empty: instr = NOP_INSTR, instr_vld = 0.
- Pop: head is popped on a clock where instr_vld=1, stall_IM_ID=0 and flow_change_ID_EX=0.
- Latency:
  - Steady-state throughput is one instruction per 3 cycles (IM bandwidth bound).
  - After reset release, reads issue in cycles 0, 1, 2 and data arrives in cycles 1, 2, 3.
  - The first instruction is pushed at the end of cycle 3 and instr_vld = 1 in cycle 4.
- Redirect (flow_change_ID_EX = 1):
  - Next clock: queue emptied, assembly discarded, phase = 0, fetch PC = dst_ID_EX.
  - Any read returning in the next cycle is discarded via the in-flight flag clearing.
  - im_re = 0 during the redirect cycle; the first read at dst_ID_EX issues the cycle after.
- Simultaneous events:
  - Redirect beats pop, push and capture.
  - Pop and push in the same clock: count unchanged, data ordering preserved.
  - Push when the queue would be full cannot occur (issue rule guarantees it); the bench asserts this.
- Stall: stall_IM_ID holds the head. Fetch continues until the issue rule blocks it, so no data is lost.
- Reset mid-assembly: partial words are discarded; restart at address 0.

Decomposition:
- Shared package / common include:
  - NOP_INSTR encoding.
  - INSTR_W = 48 and IM_W = 16.
  - Word-order constants.
- Sub-module ifq_fifo:
  - Parameterised QDEPTH × (48 + PC_W) queue.
  - Ports: push, pop, flush, head data, count, full/empty.
  - Wrap-around pointers plus a count register.

Test Plan:
- Reset, IM holding instructions 48'h0A1B2C3D4E5F at words 0–2 and 48'h123456789ABC at words 3–5, no stalls → instr_vld first high in cycle 4 with instr = 48'h0A1B2C3D4E5F and nxt_pc = 3. Next instruction 48'h123456789ABC appears 3 cycles later with nxt_pc = 6.
- Hold stall_IM_ID = 1 for 10 cycles after the first valid instruction → instr is stable at the first instruction. im_re drops once QDEPTH instructions are buffered. Releasing the stall delivers both buffered instructions on back-to-back cycles.
- Redirect scenario: flow_change_ID_EX = 1 with dst_ID_EX = 16'h0040 during a phase-1 capture.
  - Next cycle: instr_vld = 0 and instr = 0.
  - The in-flight word is dropped and the first im_addr after the redirect is 16'h0040.
  - The first valid instruction is the one at 0x40–0x42, with nxt_pc = 16'h0043.
- Redirect coinciding with a pop and a phase-2 push → queue ends empty. No stale instruction ever has instr_vld = 1.
- PC wrap: redirect to 16'hFFFE → reads issue at FFFE, FFFF, 0000. The assembled instruction has nxt_pc = 16'h0001.
- Assert rst_n low while mid-assembly at phase 1 → all outputs return to reset values asynchronously. After release, fetch restarts at address 0.
